// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-addressable RAM subsystem: command
// encodings, default geometry and the frame width used by the SPI slave.
package spi_pkg;

  localparam int unsigned DEF_MEM_DEPTH = 256;
  localparam int unsigned DEF_ADDR_SIZE = 8;
  localparam int unsigned FRAME_W       = DEF_ADDR_SIZE + 2;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_array.sv
// Byte storage with one write port and one registered read port.
// Addresses at or beyond MEM_DEPTH are masked: writes are dropped and
// reads return zero.
//   clk, rst_n           clock / async active-low reset (read register only)
//   we, waddr, wdata     write port
//   re, raddr, rdata     synchronous read port; rdata holds until next re
module spi_ram_array #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [ADDR_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE-1:0] rdata
);

  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);

  logic [ADDR_SIZE-1:0] mem [0:MEM_DEPTH-1];
  logic                 waddr_ok_c;
  logic                 raddr_ok_c;

  // Range qualification, one bit wider so MEM_DEPTH = 2^ADDR_SIZE fits
  always_comb begin
    waddr_ok_c = {1'b0, waddr} < DEPTH;
    raddr_ok_c = {1'b0, raddr} < DEPTH;
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we && waddr_ok_c) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register; out-of-range reads yield zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= raddr_ok_c ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/spi_ram.sv
// Command-decoding byte RAM fed by the SPI slave. Each rx_valid strobe
// carries one frame {cmd[1:0], payload}; commands load the write/read
// address, write a byte, or read a byte back for transmission.
//   clk, rst_n   clock / async active-low reset
//   din          frame from the SPI slave
//   rx_valid     single-cycle frame strobe
//   dout         read data to the SPI slave
//   tx_valid     dout holds valid read data
module spi_ram
  import spi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid
);

  logic [1:0]           cmd_c;
  logic [ADDR_SIZE-1:0] payload_c;
  logic                 we_c;
  logic                 re_c;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  // Address advance modulo MEM_DEPTH
  function automatic logic [ADDR_SIZE-1:0] inc_wrap(input logic [ADDR_SIZE-1:0] a);
    return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + ADDR_SIZE'(1);
  endfunction

  // Frame decode
  always_comb begin
    cmd_c     = din[ADDR_SIZE+1:ADDR_SIZE];
    payload_c = din[ADDR_SIZE-1:0];
    we_c      = rx_valid && (cmd_c == CMD_WR_DATA);
    re_c      = rx_valid && (cmd_c == CMD_RD_DATA);
  end

  // Address registers and tx_valid; tx_valid follows the latest command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_valid <= 1'b0;
    end else if (rx_valid) begin
      tx_valid <= (cmd_c == CMD_RD_DATA);
      case (cmd_c)
        CMD_WR_ADDR: wr_addr <= payload_c;
        CMD_WR_DATA: wr_addr <= inc_wrap(wr_addr);
        CMD_RD_ADDR: rd_addr <= payload_c;
        default:     rd_addr <= inc_wrap(rd_addr);
      endcase
    end
  end

  spi_ram_array #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_c),
    .waddr (wr_addr),
    .wdata (payload_c),
    .re    (re_c),
    .raddr (rd_addr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram: a full-depth instance (a) and a
// MEM_DEPTH=200 instance (b) share clock and reset.
module tb_spi_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din_a, din_b;
  logic       rx_valid_a, rx_valid_b;
  logic [7:0] dout_a, dout_b;
  logic       tx_valid_a, tx_valid_b;

  int checks;
  int errors;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic       pend_a, pend_b;
  logic [7:0] e_a, e_b;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .rx_valid(rx_valid_a),
    .dout(dout_a), .tx_valid(tx_valid_a)
  );

  spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .rx_valid(rx_valid_b),
    .dout(dout_b), .tx_valid(tx_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one frame to instance sel (0=a, 1=b) on the next negedge;
  // RD_DATA frames push their expected byte to that instance's scoreboard.
  task automatic send(input bit sel, input logic [1:0] cmd, input logic [7:0] pl,
                      input logic [7:0] exp);
    @(negedge clk);
    if (!sel) begin
      din_a = {cmd, pl}; rx_valid_a = 1'b1; rx_valid_b = 1'b0;
      if (cmd == 2'b11) q_a.push_back(exp);
    end else begin
      din_b = {cmd, pl}; rx_valid_b = 1'b1; rx_valid_a = 1'b0;
      if (cmd == 2'b11) q_b.push_back(exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  // Monitors: note read strobes accepted at posedge, compare at next negedge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      pend_a <= rx_valid_a && (din_a[9:8] == 2'b11);
      pend_b <= rx_valid_b && (din_b[9:8] == 2'b11);
    end
  end

  always @(negedge clk) begin
    if (pend_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_a_unexpected: got 0x%0h expected no read", dout_a);
      end else begin
        e_a = q_a.pop_front();
        chk("rd_a_dout", 32'(dout_a), 32'(e_a));
        chk("rd_a_tx_valid", 32'(tx_valid_a), 32'd1);
      end
    end
    if (pend_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_b_unexpected: got 0x%0h expected no read", dout_b);
      end else begin
        e_b = q_b.pop_front();
        chk("rd_b_dout", 32'(dout_b), 32'(e_b));
        chk("rd_b_tx_valid", 32'(tx_valid_b), 32'd1);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    din_a = '0; din_b = '0;
    rx_valid_a = 1'b0; rx_valid_b = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_dout_a", 32'(dout_a), 32'd0);
    chk("reset_tx_valid_a", 32'(tx_valid_a), 32'd0);
    chk("reset_tx_valid_b", 32'(tx_valid_b), 32'd0);
    rst_n = 1'b1;

    // Basic write/read, then WR_ADDR clears tx_valid
    send(0, 2'b00, 8'h10, 8'h00);
    send(0, 2'b01, 8'hA5, 8'h00);
    send(0, 2'b10, 8'h10, 8'h00);
    send(0, 2'b11, 8'h00, 8'hA5);
    send(0, 2'b00, 8'h00, 8'h00);
    idle();
    chk("wr_addr_clears_tx_valid", 32'(tx_valid_a), 32'd0);

    // Auto-increment burst across the top of memory
    send(0, 2'b00, 8'hFE, 8'h00);
    send(0, 2'b01, 8'h11, 8'h00);
    send(0, 2'b01, 8'h22, 8'h00);
    send(0, 2'b01, 8'h33, 8'h00);
    send(0, 2'b10, 8'hFE, 8'h00);
    send(0, 2'b11, 8'hFF, 8'h11);
    send(0, 2'b11, 8'hFF, 8'h22);
    send(0, 2'b11, 8'hFF, 8'h33);
    idle();

    // Hold while idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_dout", 32'(dout_a), 32'h33);
      chk("hold_tx_valid", 32'(tx_valid_a), 32'd1);
    end

    // Back-to-back strobes
    send(0, 2'b00, 8'h05, 8'h00);
    send(0, 2'b01, 8'h5A, 8'h00);
    send(0, 2'b10, 8'h05, 8'h00);
    send(0, 2'b11, 8'h00, 8'h5A);
    idle();

    // Reset mid-stream with a pending WR_ADDR
    @(negedge clk);
    din_a = {2'b00, 8'h40};
    rx_valid_a = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_dout", 32'(dout_a), 32'd0);
    chk("async_reset_tx_valid", 32'(tx_valid_a), 32'd0);
    @(negedge clk);
    rx_valid_a = 1'b0;
    rst_n = 1'b1;

    // rd_addr restarted at 0, which holds 0x33 from the burst
    send(0, 2'b11, 8'h00, 8'h33);
    idle();

    // Reduced depth: wrap at 199, out-of-range write dropped and read zero
    send(1, 2'b00, 8'hC7, 8'h00);
    send(1, 2'b01, 8'h77, 8'h00);
    send(1, 2'b01, 8'h88, 8'h00);
    send(1, 2'b10, 8'h00, 8'h00);
    send(1, 2'b11, 8'h00, 8'h88);
    send(1, 2'b10, 8'hC7, 8'h00);
    send(1, 2'b11, 8'h00, 8'h77);
    send(1, 2'b00, 8'hF0, 8'h00);
    send(1, 2'b01, 8'h99, 8'h00);
    send(1, 2'b10, 8'hF0, 8'h00);
    send(1, 2'b11, 8'h00, 8'h00);
    idle();
    repeat (3) @(negedge clk);

    chk("scoreboard_a_drained", 32'(q_a.size()), 32'd0);
    chk("scoreboard_b_drained", 32'(q_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
